// File: rtl/edge_detect_bank.sv
// rtl/edge_detect_bank.sv - multi-channel synchronised, glitch-filtered edge detector with sticky pend/irq
// Define EDGE_CNT_EN to add per-channel saturating 8-bit event counters on port cnt.
module edge_detect_bank #(
   parameter int CH          = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH-1:0]     in,
   input  logic [2*CH-1:0]   mode,
   input  logic [FILT_W-1:0] filt_len,
   input  logic [CH-1:0]     clr,
   output logic [CH-1:0]     out,
   output logic [CH-1:0]     level,
   output logic [CH-1:0]     pend,
`ifdef EDGE_CNT_EN
   output logic [8*CH-1:0]   cnt,
`endif
   output logic              irq
);

   logic [CH-1:0]     sync_q [SYNC_STAGES];
   logic [FILT_W-1:0] filt_c [CH];
   logic [CH-1:0]     s;
   logic [CH-1:0]     chg;
   logic [CH-1:0]     fire;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   // chg marks the cycle a new synchronised value has persisted filt_len+1 samples.
   always_comb begin
      chg  = '0;
      fire = '0;
      for (int i = 0; i < CH; i++) begin
         chg[i]  = (s[i] != level[i]) && (filt_c[i] >= filt_len);
         fire[i] = chg[i] && (s[i] ? mode[2*i] : mode[2*i+1]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CH; i++) filt_c[i] <= '0;
         level <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (s[i] == level[i] || chg[i]) filt_c[i] <= '0;
            else                            filt_c[i] <= filt_c[i] + 1'b1;
            if (chg[i]) level[i] <= s[i];
         end
      end
   end

   // A new event outranks a simultaneous clear so no edge is ever lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out  <= '0;
         pend <= '0;
      end else begin
         out  <= fire;
         pend <= fire | (pend & ~clr);
      end
   end

   assign irq = |pend;

`ifdef EDGE_CNT_EN
   logic [7:0] ev_cnt [CH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CH; i++) ev_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (fire[i]) begin
               if (clr[i])                  ev_cnt[i] <= 8'd1;
               else if (ev_cnt[i] != 8'hFF) ev_cnt[i] <= ev_cnt[i] + 8'd1;
            end else if (clr[i]) begin
               ev_cnt[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < CH; i++) cnt[8*i +: 8] = ev_cnt[i];
   end
`endif

endmodule

// File: tb/tb_edge_detect_bank.sv
// tb/tb_edge_detect_bank.sv - scoreboard bench for edge_detect_bank
module tb_edge_detect_bank;
   localparam int CH = 8;
   localparam int SYNC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] in;
   logic [2*CH-1:0] mode;
   logic [3:0]    filt_len;
   logic [CH-1:0] clr;
   logic [CH-1:0] out, level, pend;
   logic          irq;
`ifdef EDGE_CNT_EN
   logic [8*CH-1:0] cnt;
`endif

   edge_detect_bank #(.CH(CH), .SYNC_STAGES(SYNC), .FILT_W(4)) dut (
      .clk(clk), .rst(rst), .in(in), .mode(mode), .filt_len(filt_len), .clr(clr),
      .out(out), .level(level), .pend(pend),
`ifdef EDGE_CNT_EN
      .cnt(cnt),
`endif
      .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called right after a posedge when the input change is driven.
   task automatic expect_out(input logic [7:0] v);
      exp_t e;
      e.cyc = cyc + SYNC + int'(filt_len) + 1;
      e.val = v;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("out_pulse", 32'(out), 32'(q[0].val));
            q.delete(0);
         end else if (out != '0) begin
            chk("spurious_out", 32'(out), 32'h0);
         end
      end
   end

   initial begin
      rst = 1'b0; in = '0; mode = '0; filt_len = '0; clr = '0;
      repeat (4) begin tick(1); in = ~in; end
      tick(1);
      chk("rst_out", 32'(out), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_pend", 32'(pend), 0);
      chk("rst_irq", 32'(irq), 0);
      in = '0;
      tick(1);
      rst = 1'b1;
      tick(6);
      chk("idle_level", 32'(level), 0);
      chk("idle_pend", 32'(pend), 0);

      // ch0 rise, ch1 none, ch2 both, ch3 fall
      mode = 16'h00B1;
      in[0] = 1'b1; expect_out(8'h01);
      tick(5);
      chk("rise_pend", 32'(pend), 32'h01);
      chk("rise_irq", 32'(irq), 1);
      chk("rise_level", 32'(level), 32'h01);
      in[0] = 1'b0;
      tick(5);
      chk("fall_level", 32'(level), 0);
      chk("fall_pend_kept", 32'(pend), 32'h01);
      clr = 8'h01; tick(1); clr = '0;
      chk("clr_pend", 32'(pend), 0);
      chk("clr_irq", 32'(irq), 0);

      filt_len = 4'd3;
      in[2] = 1'b1; expect_out(8'h04);
      tick(4);
      chk("filt_level_early", 32'(level), 0);
      tick(4);
      chk("filt_level_late", 32'(level), 32'h04);
      in[2] = 1'b0; expect_out(8'h04);
      tick(8);
      in[2] = 1'b1; tick(3); in[2] = 1'b0;
      tick(8);
      chk("glitch_level", 32'(level), 0);
      in[2] = 1'b1; expect_out(8'h04);
      tick(4);
      in[2] = 1'b0; expect_out(8'h04);
      tick(10);
      chk("pulse4_level", 32'(level), 0);
      chk("pulse4_pend", 32'(pend), 32'h04);
      clr = 8'hFF; tick(1); clr = '0;
      chk("clr_all_pend", 32'(pend), 0);
      chk("clr_all_irq", 32'(irq), 0);

      filt_len = 4'd0;
      in[2] = 1'b1; expect_out(8'h04);
      tick(2);
      clr = 8'h04; tick(1); clr = '0;
      chk("set_wins", 32'(pend), 32'h04);
      clr = 8'h04; tick(1); clr = '0;
      chk("clr_after_win", 32'(pend), 0);

      in[1] = 1'b1; in[3] = 1'b1;
      tick(5);
      chk("multi_level_hi", 32'(level), 32'h0E);
      chk("multi_pend_rise", 32'(pend), 0);
      in[1] = 1'b0; in[2] = 1'b0; in[3] = 1'b0; expect_out(8'h0C);
      tick(5);
      chk("multi_level_lo", 32'(level), 0);
      chk("multi_pend_fall", 32'(pend), 32'h0C);
      chk("multi_irq", 32'(irq), 1);

`ifdef EDGE_CNT_EN
      clr = 8'hFF; tick(1); clr = '0;
      chk("cnt_clr0", 32'(cnt[7:0]), 0);
      for (int n = 0; n < 300; n++) begin
         in[0] = 1'b1; expect_out(8'h01);
         tick(3);
         in[0] = 1'b0;
         tick(3);
      end
      tick(3);
      chk("cnt_sat", 32'(cnt[7:0]), 255);
      clr = 8'h01; tick(1); clr = '0;
      chk("cnt_clr", 32'(cnt[7:0]), 0);
      in[0] = 1'b1; expect_out(8'h01);
      tick(2);
      clr = 8'h01; tick(1); clr = '0;
      chk("cnt_clr_event", 32'(cnt[7:0]), 1);
      in[0] = 1'b0;
      tick(5);
`endif

      tick(5);
      chk("sb_drained", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/edge_detect_bank.md
Name: edge_detect_bank

Overview:
Multi-channel successor to the single-signal edge detector. Per channel: synchroniser, glitch filter, run-time-selectable edge type (none/rise/fall/both), one-cycle pulse output, sticky pending flag with write-1-to-clear, and a combined interrupt line. Sits between asynchronous board inputs (buttons, sensor strobes) and control FSMs or a register block.

Parameters:
CH, 8, number of independent channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_W, 4, width of glitch-filter counter and filt_len input

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
in  input  CH  raw asynchronous channel inputs
mode  input  2*CH  edge type, channel i at bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
filt_len  input  FILT_W  glitch-filter length, shared by all channels
clr  input  CH  write-1-to-clear for pend, one bit per channel
out  output  CH  one-cycle edge pulse per channel
level  output  CH  filtered, synchronised level per channel
pend  output  CH  sticky event flags
irq  output  1  OR of all pend bits

Behaviour:
- Reset (rst=0, async): all sync flops, filter counters, level, out, pend cleared to 0; irq=0. Deassertion is synchronised externally; block requires no internal release logic.
- Synchroniser: SYNC_STAGES-deep flop chain per channel, reset 0; output s[i].
- Glitch filter per channel, counter c (FILT_W bits), reset 0:
  - s==level: c<=0.
  - s!=level and c>=filt_len: level<=s, c<=0 (level change event).
  - s!=level and c<filt_len: c<=c+1.
  - Net: a new value must persist filt_len+1 consecutive cycles at the sync output; filt_len=0 disables filtering (1 cycle).
  - Pulse shorter than filt_len+1 cycles: no level change, counter returns to 0, no out.
  - filt_len changed mid-count: compare uses current value; if c already >= new filt_len, accept at next edge.
- Edge detect: out[i] registered, high exactly one cycle, set at the same edge level[i] changes when mode[i] matches direction (01: 0->1, 10: 1->0, 11: either). mode 00: out never asserts; level still tracks.
- Latency: input change settled before edge 1 -> out high following edge SYNC_STAGES+filt_len+1, for one cycle. Default (2, filt_len=0): out high after edge 3.
- Mode change takes effect at next edge; a mode change alone never produces a pulse.
- Input high at reset release: level starts 0, so a rise event is reported after normal latency (intentional; software masks via mode).
- pend[i]: set on out[i]; cleared by clr[i]=1 sampled on a rising edge. Set and clear in same cycle: set wins (pend stays 1).
- irq = |pend, combinational from registers (glitch-free).
- Channels fully independent; simultaneous events on several channels all reported same cycle.

Optional Feature:
EDGE_CNT_EN defined: adds output cnt (8*CH bits, channel i at [8i+7:8i]); per-channel 8-bit counter increments on each out[i] pulse, saturates at 255, reset 0, cleared by clr[i]; clr and event same cycle -> count=1. Not defined: cnt port and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold rst=0 with in toggling -> out, level, pend, irq all 0; release -> no activity while in=0.
- Rise only, CH0 mode=01, filt_len=0: in[0] 0->1 -> out[0] high one cycle after edge 3, pend[0]=1, irq=1; 1->0 -> no out.
- Both edges, mode=11, filt_len=3: 1 pulse per transition, each 3 cycles later than filt_len=0; 3-cycle glitch -> level/out unchanged, 4-cycle pulse -> two out pulses.
- Pending: set pend[2], pulse clr[2] -> pend[2]=0, irq=0; clr coinciding with new event -> pend stays 1.
- Multi-channel: mode=00 on CH1, 10 on CH3, same in edges -> CH1 no out but level follows, CH3 pulses on falls only.
- EDGE_CNT_EN: 300 rising edges on CH0 -> cnt[7:0]=255; clr[0] -> 0; clr with event -> 1.
